// File: rtl/pulse_gen_if.sv
// pulse_gen_if: config, start/stop and status signals of the pulse generator
interface pulse_gen_if #(
  parameter int CH    = 4,
  parameter int CNT_W = 16
);
  localparam int CH_W = $clog2(CH);
  logic             cfg_we;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_period;
  logic [CNT_W-1:0] cfg_width;
  logic             cfg_oneshot;
  logic [CH-1:0]    start;
  logic [CH-1:0]    stop;
  logic             us_tick;
  logic [CH-1:0]    pulse_out;
  logic [CH-1:0]    busy;
  logic [CH-1:0]    done;
  modport master (
    output cfg_we, cfg_ch, cfg_period, cfg_width, cfg_oneshot, start, stop,
    input  us_tick, pulse_out, busy, done
  );
  modport slave (
    input  cfg_we, cfg_ch, cfg_period, cfg_width, cfg_oneshot, start, stop,
    output us_tick, pulse_out, busy, done
  );
endinterface

// File: rtl/pulse_gen.sv
// pulse_gen: multi-channel periodic/one-shot pulse generator timed in microseconds
module pulse_gen #(
  parameter int CLK_MHZ = 50,
  parameter int CH      = 4,
  parameter int CNT_W   = 16
) (
  input logic        clk,
  input logic        rst_n,
  pulse_gen_if.slave bus
);
  localparam int CH_W = $clog2(CH);
  localparam int PW   = $clog2(CLK_MHZ);
  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
  logic [PW-1:0] pre;
  logic          tick;
  logic [CH-1:0] po, bsy, dn;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pre  <= '0;
      tick <= 1'b0;
    end else begin
      pre  <= (pre == PW'(CLK_MHZ - 1)) ? '0 : pre + 1'b1;
      tick <= pre == PW'(CLK_MHZ - 1);
    end
  assign bus.us_tick   = tick;
  assign bus.pulse_out = po;
  assign bus.busy      = bsy;
  assign bus.done      = dn;
  for (genvar i = 0; i < CH; i++) begin : g_ch
    state_t           st, st_n;
    logic [CNT_W-1:0] cp, cw, ap, aw, cnt, ap_n, aw_n, cnt_n, cnt1;
    logic             co, ao, ao_n, po_r, dn_r, dn_n, wr, go;
    assign wr   = bus.cfg_we && bus.cfg_ch == CH_W'(i);
    assign go   = bus.start[i] && cp != '0;
    assign cnt1 = cnt + 1'b1;
    // period end outranks the width match, so width >= period keeps the output high
    always_comb begin
      st_n  = st;
      cnt_n = cnt;
      ap_n  = ap;
      aw_n  = aw;
      ao_n  = ao;
      dn_n  = 1'b0;
      if (bus.stop[i]) st_n = IDLE;
      else if (go) begin
        ap_n  = cp;
        aw_n  = cw;
        ao_n  = co;
        cnt_n = '0;
        st_n  = cw != '0 ? HIGH : LOW;
      end else if (st != IDLE && tick) begin
        cnt_n = cnt1;
        if (cnt1 == ap) begin
          cnt_n = '0;
          dn_n  = ao;
          if (!ao) begin
            ap_n = cp;
            aw_n = cw;
            ao_n = co;
          end
          st_n = (ao || cp == '0) ? IDLE : cw != '0 ? HIGH : LOW;
        end else if (cnt1 == aw) st_n = LOW;
      end
    end
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        st   <= IDLE;
        cnt  <= '0;
        cp   <= '0;
        cw   <= '0;
        co   <= 1'b0;
        ap   <= '0;
        aw   <= '0;
        ao   <= 1'b0;
        po_r <= 1'b0;
        dn_r <= 1'b0;
      end else begin
        if (wr) begin
          cp <= bus.cfg_period;
          cw <= bus.cfg_width;
          co <= bus.cfg_oneshot;
        end
        st   <= st_n;
        cnt  <= cnt_n;
        ap   <= ap_n;
        aw   <= aw_n;
        ao   <= ao_n;
        po_r <= st_n == HIGH;
        dn_r <= dn_n;
      end
    assign po[i]  = po_r;
    assign dn[i]  = dn_r;
    assign bsy[i] = st != IDLE;
  end
endmodule

// File: tb/tb_pulse_gen.sv
// tb_pulse_gen: directed scoreboard bench for pulse_gen at 50 MHz, 4 channels
module tb_pulse_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  pulse_gen_if #(.CH(4), .CNT_W(16)) bus ();
  pulse_gen #(.CLK_MHZ(50), .CH(4), .CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {string tag; logic [31:0] exp;} exp_t;
  exp_t sb[$];
  logic tr[$];
  int checks = 0;
  int errors = 0;
  task automatic expect_val(string tag, logic [31:0] e);
    sb.push_back('{tag, e});
  endtask
  task automatic check(logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed=%0h", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s: observed=%0h expected=%0h", e.tag, obs, e.exp);
      end
    end
  endtask
  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic cfg(int c, int per, int wid, bit os);
    bus.cfg_ch = 2'(c);
    bus.cfg_period = 16'(per);
    bus.cfg_width = 16'(wid);
    bus.cfg_oneshot = os;
    bus.cfg_we = 1'b1;
    step(1);
    bus.cfg_we = 1'b0;
  endtask
  task automatic capture(int c, int n);
    tr.delete();
    tr.push_back(bus.pulse_out[c]);
    for (int k = 0; k < n; k++) begin
      step(1);
      bus.start = '0;
      bus.stop = '0;
      bus.cfg_we = 1'b0;
      tr.push_back(bus.pulse_out[c]);
    end
  endtask
  function automatic int rise(int k);
    int n = 0;
    for (int j = 0; j < tr.size(); j++)
      if (tr[j] && (j == 0 || !tr[j-1])) begin
        n++;
        if (n == k) return j;
      end
    return -1;
  endfunction
  function automatic int hlen(int j);
    int n = 0;
    if (j < 0) return -1;
    while (j < tr.size() && tr[j]) begin
      n++;
      j++;
    end
    return n;
  endfunction
  function automatic int highs();
    int n = 0;
    for (int j = 1; j < tr.size(); j++) n += int'(tr[j]);
    return n;
  endfunction
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    int r1, r2, r3, ticks, dn_at, dticks, dbusy, dpo, rises;
    logic prev;
    logic [3:0] acc;
    bus.cfg_we = 1'b0;
    bus.cfg_ch = '0;
    bus.cfg_period = '0;
    bus.cfg_width = '0;
    bus.cfg_oneshot = 1'b0;
    bus.start = '0;
    bus.stop = '0;
    #23;
    expect_val("reset_outputs", 0);
    check({bus.us_tick, bus.pulse_out, bus.busy, bus.done});
    step(1);
    rst_n = 1'b1;
    step(49);
    expect_val("tick_edge49", 0);
    check(bus.us_tick);
    step(1);
    expect_val("tick_edge50", 1);
    check(bus.us_tick);
    step(1);
    expect_val("tick_edge51", 0);
    check(bus.us_tick);
    step(49);
    expect_val("tick_edge100", 1);
    check(bus.us_tick);
    expect_val("idle_outputs", 0);
    check({bus.pulse_out, bus.busy, bus.done});
    // ch0 periodic, period 4 us, width 1 us
    cfg(0, 4, 1, 0);
    bus.start = 4'b0001;
    capture(0, 700);
    r1 = rise(1);
    r2 = rise(2);
    r3 = rise(3);
    expect_val("ch0_busy", 1);
    check(bus.busy[0]);
    expect_val("ch0_first_rise", 1);
    check(r1);
    expect_val("ch0_first_gap_in_range", 1);
    check(r1 >= 0 && r2 - r1 >= 151 && r2 - r1 <= 200);
    expect_val("ch0_period_cycles", 200);
    check(r3 - r2);
    expect_val("ch0_high_cycles", 50);
    check(hlen(r2));
    expect_val("ch0_first_high_in_range", 1);
    check(hlen(r1) >= 1 && hlen(r1) <= 50);
    // ch1 one-shot, period 3 us, width 2 us
    cfg(1, 3, 2, 1);
    bus.start = 4'b0010;
    step(1);
    bus.start = '0;
    expect_val("ch1_start_busy_pulse", 2'b11);
    check({bus.busy[1], bus.pulse_out[1]});
    ticks = 0; dn_at = -1; dticks = -1; dbusy = -1; dpo = -1; rises = 0; prev = 1'b1;
    for (int k = 0; k < 300 && dn_at < 0; k++) begin
      if (bus.done[1]) begin
        dn_at = k;
        dticks = ticks;
        dbusy = int'(bus.busy[1]);
        dpo = int'(bus.pulse_out[1]);
      end else begin
        ticks += int'(bus.us_tick);
        if (bus.pulse_out[1] && !prev) rises++;
        prev = bus.pulse_out[1];
        step(1);
      end
    end
    expect_val("ch1_done_after_ticks", 3);
    check(dticks);
    expect_val("ch1_busy_at_done", 0);
    check(dbusy);
    expect_val("ch1_pulse_at_done", 0);
    check(dpo);
    expect_val("ch1_extra_rises", 0);
    check(rises);
    step(1);
    expect_val("ch1_done_one_cycle", 0);
    check(bus.done[1]);
    capture(1, 200);
    expect_val("ch1_no_more_pulses", 0);
    check(highs());
    expect_val("ch1_stays_idle", 0);
    check(bus.busy[1]);
    // ch2 stop during HIGH, then same-cycle start+stop
    cfg(2, 4, 2, 0);
    bus.start = 4'b0100;
    step(1);
    bus.start = '0;
    expect_val("ch2_high", 1);
    check(bus.pulse_out[2]);
    bus.stop = 4'b0100;
    step(1);
    bus.stop = '0;
    expect_val("ch2_stopped", 0);
    check({bus.pulse_out[2], bus.busy[2], bus.done[2]});
    bus.start = 4'b0100;
    bus.stop = 4'b0100;
    step(1);
    bus.start = '0;
    bus.stop = '0;
    expect_val("ch2_start_stop_idle", 0);
    check({bus.pulse_out[2], bus.busy[2], bus.done[2]});
    // ch3 boundaries
    cfg(3, 0, 1, 0);
    bus.start = 4'b1000;
    step(1);
    bus.start = '0;
    expect_val("ch3_period0_ignored", 0);
    check(bus.busy[3]);
    cfg(3, 3, 0, 0);
    bus.start = 4'b1000;
    capture(3, 400);
    expect_val("ch3_width0_never_high", 0);
    check(highs());
    expect_val("ch3_width0_busy", 1);
    check(bus.busy[3]);
    cfg(3, 3, 5, 0);
    bus.start = 4'b1000;
    capture(3, 400);
    expect_val("ch3_wide_always_high", 400);
    check(highs());
    expect_val("ch3_wide_busy", 1);
    check(bus.busy[3]);
    // ch0 restart, then widen mid-run: new width only from the next period
    bus.start = 4'b0001;
    step(1);
    bus.start = '0;
    bus.cfg_ch = 2'd0;
    bus.cfg_period = 16'd4;
    bus.cfg_width = 16'd2;
    bus.cfg_oneshot = 1'b0;
    bus.cfg_we = 1'b1;
    capture(0, 700);
    r2 = rise(2);
    r3 = rise(3);
    expect_val("ch0_restart_high", 0);
    check(rise(1));
    expect_val("ch0_old_width_first", 1);
    check(hlen(0) >= 1 && hlen(0) <= 50);
    expect_val("ch0_new_width_next", 100);
    check(hlen(r2));
    expect_val("ch0_period_after_cfg", 200);
    check(r3 - r2);
    // all channels running, then asynchronous reset
    cfg(0, 4, 2, 0);
    cfg(3, 3, 5, 0);
    bus.start = 4'b1111;
    step(1);
    bus.start = '0;
    expect_val("all_running", 8'hFF);
    check({bus.pulse_out, bus.busy});
    #2;
    rst_n = 1'b0;
    #1;
    expect_val("async_reset_clear", 0);
    check({bus.us_tick, bus.pulse_out, bus.busy, bus.done});
    step(3);
    rst_n = 1'b1;
    acc = '0;
    for (int k = 0; k < 300; k++) begin
      step(1);
      acc |= bus.busy | bus.pulse_out | bus.done;
    end
    expect_val("post_reset_quiet", 0);
    check(acc);
    bus.start = 4'b1111;
    step(1);
    bus.start = '0;
    expect_val("post_reset_cfg_cleared", 0);
    check(bus.busy);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
